// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// It registers the winning operands, captures the ALU result, and returns a tagged response.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [CNT_W-1:0] op_count
);

  // state | meaning
  // IDLE  | arbitrate; accept at most one request per cycle
  // EXEC  | ALU inputs registered, result settles; capture at end of cycle
  // RESP  | resp_valid strobe for the captured result or illegal-op error
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_err_q, resp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [2:0]       win_op;
  logic             win_legal;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_is_legal = 1'b1;
      default:                                op_is_legal = 1'b0;
    endcase
  endfunction

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
    accept     = (state_q == ST_IDLE) && grant_any;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    win_a      = grant_id ? req1_a  : req0_a;
    win_b      = grant_id ? req1_b  : req0_b;
    win_op     = grant_id ? req1_op : req0_op;
    win_legal  = op_is_legal(win_op);
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_err_d    = resp_err_q;
    op_count_d    = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_grant_d = grant_id;
          resp_id_d    = grant_id;
          if (win_legal) begin
            alu_a_d  = win_a;
            alu_b_d  = win_b;
            alu_op_d = win_op;
            state_d  = ST_EXEC;
          end else begin
            // Illegal ops bypass the ALU and leave its input registers alone.
            resp_result_d = '0;
            resp_zero_d   = 1'b0;
            resp_err_d    = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        resp_result_d = alu_result;
        resp_zero_d   = alu_zero;
        resp_err_d    = 1'b0;
        op_count_d    = op_count_q + CNT_W'(1);
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= 3'b000;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_err_q    <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_err_q    <= resp_err_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_err    = resp_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model predicts grants,
// response timing and contents; directed scenarios plus randomized traffic.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]    req0_op = '0, req1_op = '0;
  logic [W-1:0]  alu_a, alu_b, alu_result, resp_result;
  logic [2:0]    alu_op;
  logic          alu_zero, resp_valid, resp_id, resp_zero, resp_err;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_err(resp_err), .op_count(op_count)
  );

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd6) || (op == 3'd7);
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);
  assign alu_zero   = (alu_result == '0);

  function automatic logic [108:0] pack(input logic r0, input logic r1, input logic rv, input logic id,
                                        input logic [W-1:0] res, input logic z, input logic err,
                                        input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op, input logic [CW-1:0] cnt);
    return {r0, r1, rv, id, res, z, err, a, b, op, cnt};
  endfunction

  // Reference model: pending responses with due cycles, and a busy window after each accept
  typedef struct {
    int         due;
    bit         id;
    logic [W-1:0] res;
    bit         z;
    bit         err;
    bit         is_legal;
  } rsp_t;

  rsp_t          q[$];
  int            cyc = 0;
  int            busy_until = 0;
  bit            m_last, m_acc, m_win;
  logic [CW-1:0] m_cnt;
  logic [W-1:0]  m_a, m_b, m_res;
  logic [2:0]    m_op;
  bit            m_z, m_err;
  bit            exp_r0, exp_r1, exp_rv, exp_id;
  logic [108:0]  exp_v, obs_v;

  task automatic model_reset();
    q.delete();
    busy_until = 0;
    m_last = 1'b1; m_acc = 1'b0; m_win = 1'b0;
    m_cnt = '0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_z = 1'b0; m_err = 1'b0;
  endtask

  task automatic predict();
    #1;
    m_acc = 1'b0; exp_rv = 1'b0; exp_id = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        rsp_t r;
        r = q.pop_front();
        exp_rv = 1'b1; exp_id = r.id;
        m_res = r.res; m_z = r.z; m_err = r.err;
        if (r.is_legal) m_cnt = m_cnt + 1'b1;
      end
      if (cyc >= busy_until && (req0_valid || req1_valid)) begin
        m_acc = 1'b1;
        m_win = (req0_valid && req1_valid) ? !m_last : req1_valid;
      end
    end
    exp_r0 = m_acc && !m_win;
    exp_r1 = m_acc && m_win;
    exp_v = pack(exp_r0, exp_r1, exp_rv, exp_id, m_res, m_z, m_err, m_a, m_b, m_op, m_cnt);
    obs_v = pack(req0_ready, req1_ready, resp_valid, resp_valid & resp_id, resp_result, resp_zero,
                 resp_err, alu_a, alu_b, alu_op, op_count);
  endtask

  task automatic advance();
    if (!reset && m_acc) begin
      rsp_t r;
      logic [W-1:0] a, b;
      logic [2:0] op;
      a  = m_win ? req1_a  : req0_a;
      b  = m_win ? req1_b  : req0_b;
      op = m_win ? req1_op : req0_op;
      m_last = m_win;
      r.id = m_win;
      if (legal(op)) begin
        r.due = cyc + 2; r.res = alu_ref(a, b, op); r.z = (r.res == '0); r.err = 1'b0; r.is_legal = 1'b1;
        m_a = a; m_b = b; m_op = op;
        busy_until = cyc + 3;
      end else begin
        r.due = cyc + 1; r.res = '0; r.z = 1'b0; r.err = 1'b1; r.is_legal = 1'b0;
        busy_until = cyc + 2;
      end
      q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    predict();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_state got=%h want=%h", obs_v, exp_v); end
    checks++;
    if ({resp_valid, resp_result, op_count, alu_op, alu_a, last_tie_probe()} !== '0)
      begin errors++; $display("FAIL reset_zero got rv=%b res=%h cnt=%h op=%b want all 0", resp_valid, resp_result, op_count, alu_op); end
    advance();
    reset = 1'b0;
  endtask

  function automatic logic last_tie_probe();
    return resp_err | resp_zero | resp_id;
  endfunction

  task automatic test_single_req0();
    req0_a = 32'hFFFF0000; req0_b = 32'h0000FFFF; req0_op = 3'b000; req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL single_req0 cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      if (k == 0) begin
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_req0_ready got=%b%b want=10", req0_ready, req1_ready); end
      end
      if (k == 2) begin
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_zero, op_count} !== {1'b1, 1'b0, 32'h0, 1'b1, CW'(1)})
          begin errors++; $display("FAIL single_req0_resp got rv=%b id=%b res=%h z=%b cnt=%0d want 1 0 00000000 1 1", resp_valid, resp_id, resp_result, resp_zero, op_count); end
      end
      advance();
      if (k == 0) req0_valid = 1'b0;
    end
  endtask

  task automatic test_single_req1();
    req1_a = 32'hFFFF0000; req1_b = 32'h0000FFFF; req1_op = 3'b010; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL single_req1 cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      if (k == 2) begin
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_zero, op_count} !== {1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, CW'(2)})
          begin errors++; $display("FAIL single_req1_resp got rv=%b id=%b res=%h z=%b cnt=%0d want 1 1 ffffffff 0 2", resp_valid, resp_id, resp_result, resp_zero, op_count); end
      end
      advance();
      if (k == 0) req1_valid = 1'b0;
    end
  endtask

  task automatic test_alternate();
    int grants[$];
    int strobes[$];
    reset = 1'b1;
    predict();
    advance();
    reset = 1'b0;
    req0_a = 32'hFFFF0000; req0_b = 32'h0000FFFF; req0_op = 3'b001;
    req1_a = 32'h0000FFFF; req1_b = 32'h0000FFFF; req1_op = 3'b110;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL alternate cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp_valid) begin
        strobes.push_back(k);
        checks++;
        if (resp_id == 1'b0 && {resp_result, resp_zero} !== {32'hFFFFFFFF, 1'b0})
          begin errors++; $display("FAIL alternate_r0_data got=%h z=%b want ffffffff 0", resp_result, resp_zero); end
        else if (resp_id == 1'b1 && {resp_result, resp_zero} !== {32'h0, 1'b1})
          begin errors++; $display("FAIL alternate_r1_data got=%h z=%b want 00000000 1", resp_result, resp_zero); end
      end
      advance();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (grants.size() != 4) begin errors++; $display("FAIL alternate_grant_count got=%0d want=4", grants.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (grants[i] != i % 2) begin errors++; $display("FAIL alternate_grant_order idx=%0d got=%0d want=%0d", i, grants[i], i % 2); end
    end
    for (int i = 1; i < strobes.size(); i++) begin
      checks++;
      if (strobes[i] - strobes[i-1] != 3) begin errors++; $display("FAIL alternate_spacing got=%0d want=3", strobes[i] - strobes[i-1]); end
    end
    for (int k = 0; k < 3; k++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL alternate_drain cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      advance();
    end
  endtask

  task automatic test_illegal();
    req0_a = 32'h12345678; req0_b = 32'h9ABCDEF0; req0_op = 3'b101; req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL illegal cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      if (k == 1) begin
        checks++;
        if ({resp_valid, resp_err, resp_result, resp_zero, alu_op, op_count} !== {1'b1, 1'b1, 32'h0, 1'b0, 3'b110, CW'(4)})
          begin errors++; $display("FAIL illegal_resp got rv=%b err=%b res=%h z=%b op=%b cnt=%0d want 1 1 0 0 110 4", resp_valid, resp_err, resp_result, resp_zero, alu_op, op_count); end
      end
      advance();
      if (k == 0) req0_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    req0_a = 32'hA5A5A5A5; req0_b = 32'hFFFFFFFF; req0_op = 3'b000; req0_valid = 1'b1;
    predict();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_mid_accept got=%h want=%h", obs_v, exp_v); end
    advance();
    req0_valid = 1'b0;
    reset = 1'b1;
    predict();
    checks++;
    if ({resp_valid, resp_result, alu_a, alu_b, alu_op, op_count, resp_err} !== '0)
      begin errors++; $display("FAIL reset_mid_zero got rv=%b res=%h a=%h op=%b cnt=%0d want all 0", resp_valid, resp_result, alu_a, alu_op, op_count); end
    advance();
    reset = 1'b0;
    req0_op = 3'b010; req1_a = 32'h1; req1_b = 32'h2; req1_op = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    predict();
    checks++;
    if ({req0_ready, req1_ready, resp_valid} !== 3'b100) begin errors++; $display("FAIL reset_mid_tie got=%b%b rv=%b want 10 0", req0_ready, req1_ready, resp_valid); end
    advance();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL reset_mid_after cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      advance();
    end
  endtask

  task automatic test_xor_wrap();
    logic [2:0] ops [5];
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd6; ops[4] = 3'd7;
    reset = 1'b1;
    predict();
    advance();
    reset = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (n == 0) begin
        req1_a = 32'h0000FFFF; req1_b = 32'h0F0FF0F0; req1_op = 3'b111;
      end else begin
        req1_a = $urandom; req1_b = $urandom; req1_op = ops[$urandom_range(0, 4)];
      end
      req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        predict();
        checks++;
        if (obs_v !== exp_v) begin errors++; $display("FAIL xor_wrap op=%0d cyc=%0d got=%h want=%h", n, k, obs_v, exp_v); end
        if (k == 2 && n == 0) begin
          checks++;
          if (resp_result !== 32'h0F0F0F0F) begin errors++; $display("FAIL xor_result got=%h want=0f0f0f0f", resp_result); end
        end
        if (k == 2 && n == 14) begin
          checks++;
          if (op_count !== 4'hF) begin errors++; $display("FAIL count_full got=%h want=f", op_count); end
        end
        if (k == 2 && n == 15) begin
          checks++;
          if (op_count !== 4'h0) begin errors++; $display("FAIL count_wrap got=%h want=0", op_count); end
        end
        advance();
        if (k == 0) req1_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    bit p0 = 1'b0, p1 = 1'b0;
    bit acc0, acc1;
    for (int k = 0; k < 1500; k++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
        req0_op = 3'($urandom_range(0, 7));
      end else if (p0 && $urandom_range(0, 15) == 0) begin
        p0 = 1'b0;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
        req1_op = 3'($urandom_range(0, 7));
      end else if (p1 && $urandom_range(0, 15) == 0) begin
        p1 = 1'b0;
      end
      req0_valid = p0; req1_valid = p1;
      predict();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", k, obs_v, exp_v); end
      acc0 = m_acc && !m_win;
      acc1 = m_acc && m_win;
      advance();
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_req0();
    test_single_req1();
    test_alternate();
    test_illegal();
    test_reset_mid();
    test_xor_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
